stopwatch_ctrl: RTL and testbench
=================================

# stopwatch_ctrl

Run-control sequencer for the MM:SS time counter. It turns three raw push-buttons (start/stop, lap, clear) into a gated one-second count enable and a synchronous clear for the BCD counter, plus a display-hold level for the digit latch. It sits between the clock divider (it consumes the 1 kHz enable) and the BCD counter (its `cnt_en` replaces the free-running 1 Hz enable). It owns the sub-second phase, so pause/resume loses no fraction of a second.

## Interface
- `DB_MS`, 10: consecutive equal 1 kHz samples required to accept a button level (min 2)
- `MS_PER_SEC`, 1000: 1 kHz ticks per counted second (benches use small values, min 2)

- `clk`  in  1  system clock, 100 MHz
- `rst`  in  1  reset, asynchronous, active-high
- `en_1khz`  in  1  one-cycle pulse every 1 ms from the clock divider
- `btn_start`  in  1  raw start/stop button, active-high, asynchronous
- `btn_lap`  in  1  raw lap button, active-high, asynchronous
- `btn_clr`  in  1  raw clear button, active-high, asynchronous
- `cnt_en`  out  1  one-cycle count pulse to the BCD counter
- `cnt_clr`  out  1  one-cycle clear pulse to the BCD counter
- `disp_hold`  out  1  level; freezes the displayed value while high
- `running`  out  1  level; high in RUN or LAP (LED)
- `state`  out  2  current FSM state

## Operation
- Each button passes a 2-flop synchronizer, then a debouncer:
  - Sample on `en_1khz` only.
  - The accepted level changes after `DB_MS` consecutive samples differ from it.
  - An accepted 0→1 change gives a one-cycle `*_press` pulse. Release produces nothing.
- FSM states: IDLE=0, RUN=1, PAUSE=2, LAP=3.
  - IDLE: start → RUN. clr → stay IDLE, pulse `cnt_clr`, zero ms counter. lap ignored.
  - RUN: start → PAUSE. lap → LAP. clr ignored.
  - LAP: start → PAUSE, releasing hold. lap → RUN. clr ignored.
  - PAUSE: start → RUN. clr → IDLE, pulse `cnt_clr`, zero ms counter. lap ignored.
- Simultaneous presses in one cycle: priority start > lap > clr. Only the winner acts; the others are dropped, not queued.
- ms counter:
  - Width `$clog2(MS_PER_SEC)`.
  - Advances on `en_1khz` only when the state is RUN or LAP.
  - Wraps `MS_PER_SEC-1` → 0, and the wrap produces `cnt_en`.
  - Holds its value in PAUSE.
- `disp_hold` = 1 exactly while in LAP. `running` = 1 in RUN or LAP.
- `cnt_en` and `cnt_clr` are never high together, because clear is only accepted in non-counting states.

## Timing
- Reset values: state IDLE, ms counter 0, debouncer levels 0, all outputs 0.
- Reset mid-operation aborts immediately: the hold drops, and no `cnt_clr` is issued (the counter resets on the same `rst`).
- Button to `*_press`: 2 sync cycles, plus `DB_MS` 1 kHz samples, plus 1 cycle.
- `*_press` to state change: 1 cycle, registered.
- `cnt_clr` is asserted in the cycle the new state is visible.
- `cnt_en` is registered: high in the cycle after the `en_1khz` that wraps the counter.
- An `en_1khz` in the same cycle as a press is evaluated against the pre-transition state:
  - In RUN with start pressed, that tick still counts.
  - In PAUSE with start pressed, it does not.
- First `cnt_en` after start from IDLE: exactly `MS_PER_SEC` `en_1khz` pulses later.

## Configuration
- `STOPWATCH_LAP_EN` defined: lap button, LAP state and `disp_hold` are as above.
- Undefined:
  - No lap debouncer is instantiated and `btn_lap` is unused.
  - `disp_hold` is tied 0.
  - LAP is unreachable; encoding 3 stays reserved and is decoded as RUN for safety.

## Structure
- Shared package `stopwatch_pkg`: state encoding constants IDLE/RUN/PAUSE/LAP, `ST_W`=2, default `DB_MS`/`MS_PER_SEC`.
- Sub-module `btn_debounce` (params `DB_MS`; ports `clk`, `rst`, `en_1khz`, `btn_raw` → `press`), instantiated once per button.
- Top holds the FSM, ms counter and output registers.

## Test plan
- `MS_PER_SEC`=4, `DB_MS`=2: press start → state RUN; `cnt_en` fires on every 4th `en_1khz`, starting exactly 4 ticks after the transition.
- RUN, ms counter at 2: press start → PAUSE. Hold 20 ticks with no `cnt_en`. Press start → RUN. The next `cnt_en` comes after 2 ticks, not 4.
- Glitch: button high for 1 sample then low → no press, state unchanged. Held for 2 samples → exactly one press, even if held 100 ms.
- LAP path (macro defined): RUN → lap → `disp_hold`=1, `cnt_en` continues. Lap again → `disp_hold`=0, state RUN.
- Start and clr pressed in the same cycle in PAUSE → RUN, `cnt_clr` stays 0. Clr alone in PAUSE → IDLE, one `cnt_clr` pulse, ms counter 0.
- Assert `rst` while in LAP with ms counter at 3 → all outputs 0 asynchronously. After release: IDLE, and a start press yields the first `cnt_en` after 4 ticks.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch run-control slice: state encoding and default timing.
package stopwatch_pkg;

  localparam int unsigned ST_W           = 2;
  localparam int unsigned DB_MS_DEF      = 10;
  localparam int unsigned MS_PER_SEC_DEF = 1000;

  typedef enum logic [ST_W-1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } state_e;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, 1 kHz-sampled debouncer, one-cycle press pulse.
module btn_debounce
  import stopwatch_pkg::*;
#(
  parameter int unsigned DB_MS = DB_MS_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en_1khz,
  input  logic btn_raw,
  output logic press
);

  localparam int unsigned CNT_W = $clog2(DB_MS);

  logic             sync1_q, sync2_q;
  logic             level_q;
  logic             press_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      press_q <= 1'b0;
      if (en_1khz) begin
        // cnt_q counts consecutive samples that disagree with the accepted level
        if (sync2_q == level_q) begin
          cnt_q <= '0;
        end else if (cnt_q == CNT_W'(DB_MS - 1)) begin
          level_q <= sync2_q;
          cnt_q   <= '0;
          press_q <= sync2_q;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign press = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run-control FSM, sub-second phase counter and count/clear/hold outputs.
// Define STOPWATCH_LAP_EN to enable the lap button, LAP state and disp_hold.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned DB_MS      = DB_MS_DEF,
  parameter int unsigned MS_PER_SEC = MS_PER_SEC_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en_1khz,
  input  logic            btn_start,
  input  logic            btn_lap,
  input  logic            btn_clr,
  output logic            cnt_en,
  output logic            cnt_clr,
  output logic            disp_hold,
  output logic            running,
  output logic [ST_W-1:0] state
);

  localparam int unsigned MS_W = $clog2(MS_PER_SEC);

  logic            start_press, lap_press, clr_press;
  state_e          state_q, state_d;
  logic [MS_W-1:0] ms_q, ms_d;
  logic            cnt_en_q, cnt_en_d;
  logic            cnt_clr_q, cnt_clr_d;
  logic            run_q;
  logic            counting;

  btn_debounce #(.DB_MS(DB_MS)) u_db_start (
    .clk(clk), .rst(rst), .en_1khz(en_1khz), .btn_raw(btn_start), .press(start_press)
  );

  btn_debounce #(.DB_MS(DB_MS)) u_db_clr (
    .clk(clk), .rst(rst), .en_1khz(en_1khz), .btn_raw(btn_clr), .press(clr_press)
  );

`ifdef STOPWATCH_LAP_EN
  logic hold_q;

  btn_debounce #(.DB_MS(DB_MS)) u_db_lap (
    .clk(clk), .rst(rst), .en_1khz(en_1khz), .btn_raw(btn_lap), .press(lap_press)
  );

  assign disp_hold = hold_q;
`else
  logic unused_btn_lap;

  assign unused_btn_lap = btn_lap;
  assign lap_press      = 1'b0;
  assign disp_hold      = 1'b0;
`endif

  always_comb begin
    // Reserved encoding 3 counts like RUN when the lap feature is absent.
    counting  = (state_q != IDLE) && (state_q != PAUSE);
    state_d   = state_q;
    ms_d      = ms_q;
    cnt_en_d  = 1'b0;
    cnt_clr_d = 1'b0;

    if (en_1khz && counting) begin
      if (ms_q == MS_W'(MS_PER_SEC - 1)) begin
        ms_d     = '0;
        cnt_en_d = 1'b1;
      end else begin
        ms_d = ms_q + 1'b1;
      end
    end

    // Global priority start > lap > clr; a losing press is dropped even if the winner is ignored.
    case (state_q)
      IDLE, PAUSE: begin
        if (start_press) begin
          state_d = RUN;
        end else if (!lap_press && clr_press) begin
          state_d   = IDLE;
          ms_d      = '0;
          cnt_clr_d = 1'b1;
        end
      end
      default: begin
        if (start_press) begin
          state_d = PAUSE;
        end else if (lap_press) begin
          state_d = (state_q == LAP) ? RUN : LAP;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ms_q      <= '0;
      cnt_en_q  <= 1'b0;
      cnt_clr_q <= 1'b0;
      run_q     <= 1'b0;
`ifdef STOPWATCH_LAP_EN
      hold_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ms_q      <= ms_d;
      cnt_en_q  <= cnt_en_d;
      cnt_clr_q <= cnt_clr_d;
      run_q     <= (state_d == RUN) || (state_d == LAP);
`ifdef STOPWATCH_LAP_EN
      hold_q    <= (state_d == LAP);
`endif
    end
  end

  assign cnt_en  = cnt_en_q;
  assign cnt_clr = cnt_clr_q;
  assign running = run_q;
  assign state   = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Randomized scoreboard bench for stopwatch_ctrl against a behavioural stopwatch model.
`timescale 1ns/1ps
module tb_stopwatch_ctrl;

  localparam int DB = 2;
  localparam int MS = 4;
`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_LAP = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       en_1khz = 1'b0;
  logic       btn_start = 1'b0, btn_lap = 1'b0, btn_clr = 1'b0;
  logic       cnt_en, cnt_clr, disp_hold, running;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;

  typedef struct {
    longint t;
    bit     clr;
  } ev_t;
  ev_t sb[$];

  always #5 clk = ~clk;

  stopwatch_ctrl #(.DB_MS(DB), .MS_PER_SEC(MS)) dut (
    .clk(clk), .rst(rst), .en_1khz(en_1khz),
    .btn_start(btn_start), .btn_lap(btn_lap), .btn_clr(btn_clr),
    .cnt_en(cnt_en), .cnt_clr(cnt_clr), .disp_hold(disp_hold),
    .running(running), .state(state)
  );

  // Reference: button pipeline = 2-cycle delay, accept after DB disagreeing ticks;
  // elapsed ms counted while running, a count pulse on every MS-th elapsed ms.
  int   m_state = S_IDLE;
  int   m_elapsed = 0;
  bit   s1[3], s2[3], lvl[3], prs[3];
  int   runlen[3];
  bit   ps, pl, pc;
  int   st;
  logic [2:0] rawv;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state   = S_IDLE;
      m_elapsed = 0;
      sb.delete();
      for (int b = 0; b < 3; b++) begin
        s1[b] = 0; s2[b] = 0; lvl[b] = 0; prs[b] = 0; runlen[b] = 0;
      end
    end else begin
      ps = prs[0];
      pl = LAP_EN && prs[1];
      pc = prs[2];
      st = m_state;
      if (en_1khz && (st == S_RUN || st == S_LAP)) begin
        m_elapsed++;
        if (m_elapsed % MS == 0) sb.push_back(ev_t'{t: $time + 5, clr: 1'b0});
      end
      if (ps) begin
        m_state = (st == S_IDLE || st == S_PAUSE) ? S_RUN : S_PAUSE;
      end else if (pl) begin
        if (st == S_RUN) m_state = S_LAP;
        else if (st == S_LAP) m_state = S_RUN;
      end else if (pc && (st == S_IDLE || st == S_PAUSE)) begin
        m_state   = S_IDLE;
        m_elapsed = 0;
        sb.push_back(ev_t'{t: $time + 5, clr: 1'b1});
      end
      rawv = {btn_clr, btn_lap, btn_start};
      for (int b = 0; b < 3; b++) begin
        prs[b] = 0;
        if (en_1khz) begin
          if (s2[b] != lvl[b]) begin
            runlen[b]++;
            if (runlen[b] == DB) begin
              lvl[b] = s2[b]; runlen[b] = 0; prs[b] = s2[b];
            end
          end else begin
            runlen[b] = 0;
          end
        end
        s2[b] = s1[b];
        s1[b] = rawv[b];
      end
    end
  end

  // Monitor: pulses against the scoreboard, status levels against the model every cycle.
  bit   have, exp_en, exp_clr, exp_run, exp_hold;
  ev_t  e;
  always @(negedge clk) begin
    have = 0; exp_en = 0; exp_clr = 0;
    while (sb.size() > 0 && sb[0].t < $time) begin
      total++; bad++;
      e = sb.pop_front();
      $display("FAIL stale_pulse t=%0d clr=%0b got none required pulse", e.t, e.clr);
    end
    if (sb.size() > 0 && sb[0].t == $time) begin
      e = sb.pop_front();
      have = 1; exp_en = !e.clr; exp_clr = e.clr;
    end
    if (have || cnt_en || cnt_clr) begin
      total++;
      if ({cnt_en, cnt_clr} !== {exp_en, exp_clr}) begin
        bad++;
        $display("FAIL pulse t=%0t got en=%b clr=%b required en=%b clr=%b",
                 $time, cnt_en, cnt_clr, exp_en, exp_clr);
      end
    end
    exp_run  = (m_state == S_RUN || m_state == S_LAP);
    exp_hold = LAP_EN && (m_state == S_LAP);
    total++;
    if ({state, running, disp_hold} !== {2'(m_state), exp_run, exp_hold}) begin
      bad++;
      $display("FAIL status t=%0t got st=%0d run=%b hold=%b required st=%0d run=%b hold=%b",
               $time, state, running, disp_hold, m_state, exp_run, exp_hold);
    end
  end

  task automatic step(input bit e1);
    @(posedge clk);
    #2;
    en_1khz = e1;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      step(1'b1);
      repeat ($urandom_range(1, 3)) step(1'b0);
    end
  endtask

  task automatic press(input bit s, input bit l, input bit c, input int hold);
    btn_start = s; btn_lap = l; btn_clr = c;
    ticks(hold);
    btn_start = 0; btn_lap = 0; btn_clr = 0;
    ticks(3);
  endtask

  task automatic pulse_rst();
    step(1'b0);
    rst = 1'b1;
    step(1'b0);
    step(1'b0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) step(1'b0);
    rst = 1'b0;
    ticks(2);

    press(1, 0, 0, 3);            // IDLE -> RUN
    ticks(13);
    press(1, 0, 0, 3);            // RUN -> PAUSE
    ticks(20);
    press(1, 0, 0, 3);            // PAUSE -> RUN, phase preserved
    ticks(9);
    btn_start = 1; ticks(1); btn_start = 0;   // single-sample glitch
    ticks(4);
    press(1, 0, 0, 100);          // long hold: one press, RUN -> PAUSE
    press(1, 0, 0, 3);            // PAUSE -> RUN
    if (LAP_EN) begin
      press(0, 1, 0, 3); ticks(6);
      press(0, 1, 0, 3); ticks(3);
      press(0, 1, 0, 3);
    end
    press(1, 0, 0, 3);            // -> PAUSE
    press(1, 0, 1, 3);            // start beats clr: RUN, no clear
    press(1, 0, 0, 3);            // -> PAUSE
    press(0, 0, 1, 3);            // -> IDLE with clear
    press(1, 0, 0, 3);            // -> RUN
    if (LAP_EN) press(0, 1, 0, 3);
    ticks(1);
    pulse_rst();
    press(1, 0, 0, 3);
    ticks(10);

    repeat (250) begin
      if ($urandom_range(0, 24) == 0) pulse_rst();
      btn_start = ($urandom_range(0, 3) == 0);
      btn_lap   = ($urandom_range(0, 3) == 0);
      btn_clr   = ($urandom_range(0, 4) == 0);
      ticks($urandom_range(1, 4));
    end

    btn_start = 0; btn_lap = 0; btn_clr = 0;
    ticks(6);
    repeat (5) step(1'b0);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain got pending=%0d required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
